// File: rtl/contador_busca512.sv
// contador_busca512: program counter and instruction-fetch sequencer feeding a valid/ready consumer
module contador_busca512 #(
  parameter int LARGURA_DADO = 16,
  parameter int LARGURA_END = 9,
  parameter logic [LARGURA_END-1:0] END_INICIAL = '0
) (
  input  logic                    sinal_clock,
  input  logic                    sinal_reset,
  input  logic                    habilita,
  input  logic                    carrega,
  input  logic [LARGURA_END-1:0]  endereco_salto,
  input  logic [LARGURA_DADO-1:0] dado_memoria,
  output logic [LARGURA_END-1:0]  posicao_mem,
  output logic [LARGURA_DADO-1:0] instrucao,
  output logic                    instrucao_valida,
  input  logic                    consumidor_pronto,
  output logic [LARGURA_END-1:0]  pc_atual,
  output logic                    volta_completa
);
  typedef enum logic [1:0] {OCIOSO, BUSCA, ESPERA} estado_t;
  estado_t                 r_estado;
  logic [LARGURA_END-1:0]  r_pc, r_pc_atual;
  logic [LARGURA_DADO-1:0] r_instrucao;
  logic                    r_valida, r_volta;
  logic                    w_transfer, w_captura;
  assign w_transfer = r_valida & consumidor_pronto;
  // A new word is taken on the first fetch cycle or on every accepted handoff while running
  assign w_captura = habilita & ((r_estado == BUSCA) | ((r_estado == ESPERA) & w_transfer));
  always_ff @(posedge sinal_clock or posedge sinal_reset)
    if (sinal_reset) begin
      r_estado    <= OCIOSO;
      r_pc        <= END_INICIAL;
      r_pc_atual  <= '0;
      r_instrucao <= '0;
      r_valida    <= 1'b0;
      r_volta     <= 1'b0;
    end else if (carrega) begin
      r_pc     <= endereco_salto;
      r_valida <= 1'b0;
      r_volta  <= 1'b0;
      r_estado <= habilita ? BUSCA : OCIOSO;
    end else begin
      if (w_captura) begin
        r_instrucao <= dado_memoria;
        r_pc_atual  <= r_pc;
        r_pc        <= r_pc + 1'b1;
        if (&r_pc) r_volta <= 1'b1;
      end
      case (r_estado)
        OCIOSO: r_estado <= habilita ? BUSCA : OCIOSO;
        BUSCA: begin
          r_valida <= habilita;
          r_estado <= habilita ? ESPERA : OCIOSO;
        end
        ESPERA: if (w_transfer && !habilita) begin
          r_valida <= 1'b0;
          r_estado <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  assign posicao_mem      = r_pc;
  assign instrucao        = r_instrucao;
  assign instrucao_valida = r_valida;
  assign pc_atual         = r_pc_atual;
  assign volta_completa   = r_volta;
endmodule

// File: tb/tb_contador_busca512.sv
// tb_contador_busca512: directed fetch, backpressure, jump, wrap, stop and async-reset checks
module tb_contador_busca512;
  logic        clk = 1'b0;
  logic        rst, habilita, carrega, pronto;
  logic [8:0]  salto;
  logic [15:0] dado;
  logic [8:0]  posicao, pc_atual;
  logic [15:0] instr;
  logic        valida, volta;
  logic [15:0] mem [512];
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  assign dado = mem[posicao];
  contador_busca512 dut (
    .sinal_clock(clk), .sinal_reset(rst), .habilita(habilita), .carrega(carrega),
    .endereco_salto(salto), .dado_memoria(dado), .posicao_mem(posicao), .instrucao(instr),
    .instrucao_valida(valida), .consumidor_pronto(pronto), .pc_atual(pc_atual),
    .volta_completa(volta)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic word(input string tag, input logic [15:0] i, input logic [8:0] pa, input logic [8:0] pm);
    chk({tag, "_valida"}, 32'(valida), 32'd1);
    chk({tag, "_instr"}, 32'(instr), 32'(i));
    chk({tag, "_pc_atual"}, 32'(pc_atual), 32'(pa));
    chk({tag, "_posicao"}, 32'(posicao), 32'(pm));
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hC000 | 16'(i);
    for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
    mem[300] = 16'hBEEF;
    mem[510] = 16'hA510;
    mem[511] = 16'hA511;
    rst = 1'b1; habilita = 1'b0; carrega = 1'b0; pronto = 1'b0; salto = '0;
    step(); step();
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_valida", 32'(valida), 32'd0);
    chk("rst_pc_atual", 32'(pc_atual), 32'd0);
    chk("rst_volta", 32'(volta), 32'd0);
    chk("rst_posicao", 32'(posicao), 32'd0);
    rst = 1'b0; habilita = 1'b1; pronto = 1'b1;
    step();
    chk("lat_edge1_valida", 32'(valida), 32'd0);
    step();
    word("fetch0", 16'h1000, 9'd0, 9'd1);
    step();
    word("fetch1", 16'h1001, 9'd1, 9'd2);
    pronto = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      word("hold", 16'h1001, 9'd1, 9'd2);
    end
    pronto = 1'b1;
    step();
    word("fetch2", 16'h1002, 9'd2, 9'd3);
    step();
    word("fetch3", 16'h1003, 9'd3, 9'd4);
    pronto = 1'b0; carrega = 1'b1; salto = 9'd300;
    step();
    chk("jump_flush_valida", 32'(valida), 32'd0);
    chk("jump_posicao", 32'(posicao), 32'd300);
    carrega = 1'b0;
    step();
    word("jump_target", 16'hBEEF, 9'd300, 9'd301);
    carrega = 1'b1; salto = 9'd510;
    step();
    chk("wrapjump_valida", 32'(valida), 32'd0);
    chk("wrapjump_posicao", 32'(posicao), 32'd510);
    carrega = 1'b0; pronto = 1'b1;
    step();
    word("w510", 16'hA510, 9'd510, 9'd511);
    chk("w510_volta", 32'(volta), 32'd0);
    step();
    word("w511", 16'hA511, 9'd511, 9'd0);
    chk("w511_volta", 32'(volta), 32'd1);
    step();
    word("w0", 16'h1000, 9'd0, 9'd1);
    chk("w0_volta_sticky", 32'(volta), 32'd1);
    carrega = 1'b1; salto = 9'd2;
    step();
    chk("clr_volta", 32'(volta), 32'd0);
    chk("clr_valida", 32'(valida), 32'd0);
    carrega = 1'b0;
    step();
    word("re2", 16'h1002, 9'd2, 9'd3);
    step();
    word("re3", 16'h1003, 9'd3, 9'd4);
    habilita = 1'b0;
    step();
    chk("stop_valida", 32'(valida), 32'd0);
    chk("stop_instr_kept", 32'(instr), 32'h1003);
    chk("stop_pc_atual_kept", 32'(pc_atual), 32'd3);
    chk("stop_posicao", 32'(posicao), 32'd4);
    step();
    chk("idle_valida", 32'(valida), 32'd0);
    chk("idle_posicao", 32'(posicao), 32'd4);
    habilita = 1'b1;
    step();
    chk("resume_busca_valida", 32'(valida), 32'd0);
    step();
    word("resume4", 16'hC004, 9'd4, 9'd5);
    pronto = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_valida", 32'(valida), 32'd0);
    chk("async_instr", 32'(instr), 32'h0);
    chk("async_pc_atual", 32'(pc_atual), 32'd0);
    chk("async_posicao", 32'(posicao), 32'd0);
    chk("async_volta", 32'(volta), 32'd0);
    step();
    chk("held_rst_valida", 32'(valida), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
